// File: rtl/laser_tx_framer.sv
// Byte-to-laser transmit framer: bytes are queued in a small FIFO and sent as start, 8 data bits LSB-first, stop.
// Bits advance on rising edges of the divider output; the divider is enabled only while a frame is in flight.
module laser_tx_framer #(
    parameter int DEPTH = 4
) (
    input  logic       clk_base,
    input  logic       reset,
    input  logic       bit_clk,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       divider_en,
    output logic       laser_out,
    output logic       busy,
    output logic       frame_done
);
    localparam int AW = $clog2(DEPTH);

    // state | meaning
    // IDLE  | laser off, waiting for a queued byte
    // ARM   | byte loaded, divider enabled, waiting for the first tick
    // START | start bit on the line
    // DATA  | data bits on the line; the tick after bit 7 drives the stop bit
    // STOP  | stop bit on the line; chains into the next frame if one is queued
    typedef enum logic [2:0] {IDLE, ARM, START, DATA, STOP} state_t;

    state_t      state_q;
    logic        bit_clk_q;
    logic [7:0]  shift_q;
    logic [3:0]  bit_cnt_q;
    logic        laser_q;
    logic        frame_done_q;
    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0] wr_ptr_d, rd_ptr_d;
    logic        tick, fifo_empty, fifo_full, push, pop;
    logic [7:0]  head;

    assign tick       = bit_clk & ~bit_clk_q;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push       = data_valid & ~fifo_full;
    // Pops mirror the FSM loads: IDLE takes the head at once, STOP only on its closing tick.
    assign pop        = ~fifo_empty & ((state_q == IDLE) | ((state_q == STOP) & tick));
    assign head       = mem_q[rd_ptr_q[AW-1:0]];
    assign wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
    assign rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};

    always_ff @(posedge clk_base) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk_base or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_base or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_clk_q    <= 1'b0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            laser_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            bit_clk_q    <= bit_clk;
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        shift_q   <= head;
                        bit_cnt_q <= '0;
                        state_q   <= ARM;
                    end
                end
                ARM: begin
                    if (tick) begin
                        laser_q <= 1'b1;
                        state_q <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        laser_q   <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                        bit_cnt_q <= 4'd1;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt_q == 4'd8) begin
                            laser_q <= 1'b0;
                            state_q <= STOP;
                        end else begin
                            laser_q   <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        frame_done_q <= 1'b1;
                        if (!fifo_empty) begin
                            shift_q   <= head;
                            bit_cnt_q <= '0;
                            laser_q   <= 1'b1;
                            state_q   <= START;
                        end else begin
                            laser_q <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_ready = ~fifo_full;
    assign divider_en = (state_q != IDLE);
    assign busy       = (state_q != IDLE) | ~fifo_empty;
    assign laser_out  = laser_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_laser_tx_framer.sv
// Directed bench for laser_tx_framer: a table of single-byte frames plus hand-written
// sequences for bursts, FIFO full, push/pop at the STOP tick, mid-frame reset and idle ticks.
module tb_laser_tx_framer;
    logic       clk_base   = 1'b0;
    logic       reset      = 1'b1;
    logic       bit_clk    = 1'b0;
    logic [7:0] data_in    = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready, divider_en, laser_out, busy, frame_done;

    int n_vec   = 0;
    int n_err   = 0;
    int cyc     = 0;
    int fd_cnt  = 0;
    int den_cnt = 0;
    int fd_cyc [$];
    logic early_q [$];
    logic late_q [$];
    logic exp_q [$];

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // bit 9 is the first bit on the line
    } vec_t;

    vec_t vecs [6];
    logic [7:0] full_bytes [5];
    logic       rdy_exp [5];
    int fd0, den0, nfd;

    laser_tx_framer #(.DEPTH(4)) dut (
        .clk_base   (clk_base),
        .reset      (reset),
        .bit_clk    (bit_clk),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .divider_en (divider_en),
        .laser_out  (laser_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk_base = ~clk_base;

    always @(posedge clk_base) cyc <= cyc + 1;

    always @(negedge clk_base) begin
        if (frame_done) begin
            fd_cnt++;
            fd_cyc.push_back(cyc);
        end
        if (divider_en) den_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] frame_of(input logic [7:0] b);
        return {1'b1, b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7], 1'b0};
    endfunction

    task automatic add_frame(input logic [9:0] f);
        for (int j = 9; j >= 0; j--) exp_q.push_back(f[j]);
    endtask

    task automatic clear_bits();
        early_q.delete();
        late_q.delete();
        exp_q.delete();
    endtask

    // n bit periods of 8 cycles (4 high, 4 low). laser_out is sampled just after each
    // tick edge and again just before the next one; optionally a byte is pushed on the first tick edge.
    task automatic bit_periods(input int n, input bit do_push, input logic [7:0] pb);
        @(posedge clk_base);
        #1;
        for (int i = 0; i < n; i++) begin
            bit_clk = 1'b1;
            if (i == 0 && do_push) begin
                data_in    = pb;
                data_valid = 1'b1;
            end
            @(negedge clk_base);
            if (i > 0) late_q.push_back(laser_out);
            @(posedge clk_base);
            @(negedge clk_base);
            data_valid = 1'b0;
            early_q.push_back(laser_out);
            repeat (3) @(posedge clk_base);
            #1 bit_clk = 1'b0;
            repeat (4) @(posedge clk_base);
            #1;
        end
        @(negedge clk_base);
        late_q.push_back(laser_out);
    endtask

    task automatic check_bits(input string name);
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s laser_early[%0d]", name, i), early_q[i], exp_q[i]);
            check($sformatf("%s laser_late[%0d]", name, i), late_q[i], exp_q[i]);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        @(negedge clk_base);
        data_in    = b;
        data_valid = 1'b1;
        @(negedge clk_base);
        data_valid = 1'b0;
    endtask

    task automatic push_two(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk_base);
        data_in    = a;
        data_valid = 1'b1;
        @(negedge clk_base);
        data_in    = b;
        @(negedge clk_base);
        data_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{data: 8'hA5, frame: 10'b1101001010};
        vecs[1] = '{data: 8'h00, frame: 10'b1000000000};
        vecs[2] = '{data: 8'hFF, frame: 10'b1111111110};
        vecs[3] = '{data: 8'h01, frame: 10'b1100000000};
        vecs[4] = '{data: 8'h80, frame: 10'b1000000010};
        vecs[5] = '{data: 8'h3C, frame: 10'b1001111000};
        full_bytes = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        rdy_exp    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset values
        repeat (3) @(negedge clk_base);
        check("rst laser_out", laser_out, 1'b0);
        check("rst divider_en", divider_en, 1'b0);
        check("rst data_ready", data_ready, 1'b1);
        reset = 1'b0;
        @(negedge clk_base);
        check("post-rst laser_out", laser_out, 1'b0);
        check("post-rst divider_en", divider_en, 1'b0);
        check("post-rst busy", busy, 1'b0);
        check("post-rst frame_done", frame_done, 1'b0);
        check("post-rst data_ready", data_ready, 1'b1);

        // Ticks while idle with an empty FIFO are ignored
        clear_bits();
        fd0  = fd_cnt;
        den0 = den_cnt;
        bit_periods(4, 1'b0, 8'h00);
        repeat (4) exp_q.push_back(1'b0);
        check_bits("idle");
        check("idle frame_done pulses", fd_cnt - fd0, 0);
        check("idle divider_en cycles", den_cnt - den0, 0);

        // Single-byte frames from the table
        foreach (vecs[k]) begin
            clear_bits();
            fd0 = fd_cnt;
            push_byte(vecs[k].data);
            check($sformatf("v%0d divider_en after push", k), divider_en, 1'b0);
            check($sformatf("v%0d busy after push", k), busy, 1'b1);
            @(negedge clk_base);
            check($sformatf("v%0d divider_en armed", k), divider_en, 1'b1);
            add_frame(vecs[k].frame);
            exp_q.push_back(1'b0);
            bit_periods(11, 1'b0, 8'h00);
            check_bits($sformatf("v%0d", k));
            check($sformatf("v%0d frame_done pulses", k), fd_cnt - fd0, 1);
            check($sformatf("v%0d divider_en end", k), divider_en, 1'b0);
            check($sformatf("v%0d busy end", k), busy, 1'b0);
        end

        // Burst 0x00 then 0xFF: contiguous frames, frame_done 10 periods apart
        clear_bits();
        fd0 = fd_cnt;
        nfd = fd_cyc.size();
        push_two(8'h00, 8'hFF);
        add_frame(10'b1000000000);
        add_frame(10'b1111111110);
        exp_q.push_back(1'b0);
        bit_periods(21, 1'b0, 8'h00);
        check_bits("burst");
        check("burst frame_done pulses", fd_cnt - fd0, 2);
        if (fd_cyc.size() >= nfd + 2)
            check("burst frame_done spacing", fd_cyc[nfd+1] - fd_cyc[nfd], 80);
        else
            check("burst frame_done recorded", fd_cyc.size() - nfd, 2);

        // FIFO fill while held in ARM
        clear_bits();
        fd0 = fd_cnt;
        push_byte(8'h11);
        @(negedge clk_base);
        check("full divider_en armed", divider_en, 1'b1);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("full data_ready before push %0d", k), data_ready, rdy_exp[k]);
            data_in    = full_bytes[k];
            data_valid = 1'b1;
            @(negedge clk_base);
        end
        data_valid = 1'b0;
        check("full data_ready held", data_ready, 1'b0);
        check("full busy", busy, 1'b1);
        add_frame(frame_of(8'h11));
        for (int k = 0; k < 4; k++) add_frame(frame_of(full_bytes[k]));
        exp_q.push_back(1'b0);
        bit_periods(51, 1'b0, 8'h00);
        check_bits("full");
        check("full frame_done pulses", fd_cnt - fd0, 5);
        check("full data_ready end", data_ready, 1'b1);
        check("full busy end", busy, 1'b0);

        // Push coinciding with the STOP-tick pop while one byte is queued
        clear_bits();
        fd0 = fd_cnt;
        push_two(8'h3C, 8'hC3);
        add_frame(frame_of(8'h3C));
        bit_periods(10, 1'b0, 8'h00);
        check_bits("pp first");
        check("pp divider_en in stop", divider_en, 1'b1);
        clear_bits();
        add_frame(frame_of(8'hC3));
        add_frame(frame_of(8'h96));
        exp_q.push_back(1'b0);
        bit_periods(21, 1'b1, 8'h96);
        check_bits("pp rest");
        check("pp frame_done pulses", fd_cnt - fd0, 3);
        check("pp busy end", busy, 1'b0);

        // Reset during DATA with laser high and a byte still queued
        clear_bits();
        push_two(8'h5A, 8'h77);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        bit_periods(5, 1'b0, 8'h00);
        check_bits("pre-reset");
        #2 reset = 1'b1;
        #1;
        check("async reset laser_out", laser_out, 1'b0);
        check("async reset data_ready", data_ready, 1'b1);
        check("async reset busy", busy, 1'b0);
        check("async reset divider_en", divider_en, 1'b0);
        @(negedge clk_base);
        @(negedge clk_base);
        reset = 1'b0;
        clear_bits();
        fd0  = fd_cnt;
        den0 = den_cnt;
        repeat (12) exp_q.push_back(1'b0);
        bit_periods(12, 1'b0, 8'h00);
        check_bits("post-reset idle");
        check("post-reset frame_done pulses", fd_cnt - fd0, 0);
        check("post-reset divider_en cycles", den_cnt - den0, 0);
        check("post-reset busy", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
